// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch mode controller.
// The optional lap/freeze feature is selected by STOPWATCH_LAP_EN.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PAUSE = 2'd1,
      ADJ   = 2'd2
   } state_t;

   localparam logic [1:0] BLINK_NONE = 2'b00;
   localparam logic [1:0] BLINK_MIN  = 2'b10;
   localparam logic [1:0] BLINK_SEC  = 2'b01;

   // Command strobes issued to the min:sec counter datapath
   typedef struct packed {
      logic inc_sec;
      logic inc_min;
      logic clr;
   } cmd_t;

   // sel==0 adjusts minutes, sel==1 adjusts seconds
   function automatic logic [1:0] blink_for(input logic sel);
      return sel ? BLINK_SEC : BLINK_MIN;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_edge.sv
// Synchronizes a divider clock level into clk and flags its rising edge.
// pulse_c is high for exactly one cycle, SYNC_STAGES cycles after the level is first sampled.
module tick_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic pulse_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   if (SYNC_STAGES > 1) begin : g_multi
      always_ff @(posedge clk) begin
         if (!rst_n) sync_q <= '0;
         else        sync_q <= {sync_q[SYNC_STAGES-2:0], level};
      end
   end else begin : g_single
      always_ff @(posedge clk) begin
         if (!rst_n) sync_q <= '0;
         else        sync_q <= level;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= sync_q[SYNC_STAGES-1];
   end

   assign pulse_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode sequencer: RUN/PAUSE/ADJ FSM turning ticks and buttons into counter strobes.
// Define STOPWATCH_LAP_EN to enable the lap (display freeze) toggle on sel while running.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter bit          CLR_ON_RESET = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   input  logic       pause_btn,
   input  logic       adj,
   input  logic       sel,
   input  logic       sec_max,
   output logic       inc_sec,
   output logic       inc_min,
   output logic       clr,
   output logic [1:0] blink_mask,
   output logic       running,
   output logic       freeze
);

   logic   t1_c;
   logic   t2_c;
   logic   pause_q;
   logic   pause_ev_c;
   logic   first_q;
   state_t state_q;
   state_t state_next;
   state_t pre_adj_q;
   cmd_t   cmd_d;
   logic [1:0] blink_d;
   logic   running_d;

   tick_edge #(.SYNC_STAGES(SYNC_STAGES)) u_tick_1hz (
      .clk     (clk),
      .rst_n   (rst_n),
      .level   (tick_1hz),
      .pulse_c (t1_c)
   );

   tick_edge #(.SYNC_STAGES(SYNC_STAGES)) u_tick_2hz (
      .clk     (clk),
      .rst_n   (rst_n),
      .level   (tick_2hz),
      .pulse_c (t2_c)
   );

   assign pause_ev_c = pause_btn & ~pause_q;

   // State register; pre_adj remembers where to return when adjust mode ends
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= RUN;
         pre_adj_q <= RUN;
         pause_q   <= 1'b0;
         first_q   <= 1'b1;
      end else begin
         state_q <= state_next;
         pause_q <= pause_btn;
         first_q <= 1'b0;
         if (state_q != ADJ && state_next == ADJ) pre_adj_q <= state_q;
      end
   end

   // Next state: adj outranks pause_ev
   always_comb begin
      state_next = state_q;
      case (state_q)
         RUN: begin
            if (adj)             state_next = ADJ;
            else if (pause_ev_c) state_next = PAUSE;
         end
         PAUSE: begin
            if (adj)             state_next = ADJ;
            else if (pause_ev_c) state_next = RUN;
         end
         ADJ: begin
            if (!adj)            state_next = pre_adj_q;
         end
         default:                state_next = RUN;
      endcase
   end

   // Output decode: ticks act on the current state, mode indicators on the next state
   always_comb begin
      cmd_d     = '0;
      blink_d   = BLINK_NONE;
      running_d = (state_next == RUN);
      case (state_q)
         RUN: begin
            if (t1_c) begin
               cmd_d.inc_sec = 1'b1;
               cmd_d.inc_min = sec_max;
            end
         end
         ADJ: begin
            if (t2_c) begin
               cmd_d.inc_sec = sel;
               cmd_d.inc_min = ~sel;
            end
         end
         default: ;
      endcase
      if (state_next == ADJ) blink_d = blink_for(sel);
      cmd_d.clr = CLR_ON_RESET & first_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inc_sec    <= 1'b0;
         inc_min    <= 1'b0;
         clr        <= 1'b0;
         blink_mask <= BLINK_NONE;
         running    <= 1'b0;
      end else begin
         inc_sec    <= cmd_d.inc_sec;
         inc_min    <= cmd_d.inc_min;
         clr        <= cmd_d.clr;
         blink_mask <= blink_d;
         running    <= running_d;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic sel_q;
   logic sel_ev_c;
   logic freeze_d;

   assign sel_ev_c = sel & ~sel_q;

   // Lap toggle only while staying in RUN; leaving RUN always releases the display
   always_comb begin
      freeze_d = freeze;
      if (state_next != RUN)                freeze_d = 1'b0;
      else if (state_q == RUN && sel_ev_c)  freeze_d = ~freeze;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_q  <= 1'b0;
         freeze <= 1'b0;
      end else begin
         sel_q  <= sel;
         freeze <= freeze_d;
      end
   end
`else
   assign freeze = 1'b0;
`endif

endmodule
